// File: rtl/lockin_amplitud_magnitud_if.sv
// Sample-in / amplitude-out bus of the lock-in magnitude stage.
//
// Handshake: an I/Q pair moves on a rising edge where in_valid && in_ready
// are both high; in_valid never waits on in_ready, and a pair offered while
// in_ready is low is rejected. avalonst_source_valid is a one-cycle pulse
// with no ready: the consumer must take avalonst_source_data in that cycle.
interface lockin_amplitud_magnitud_if #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32
);
   logic                    in_valid;
   logic signed [IN_W-1:0]  in_i;
   logic signed [IN_W-1:0]  in_q;
   logic                    in_ready;
   logic [OUT_W-1:0]        avalonst_source_data;
   logic                    avalonst_source_valid;

   // producer of I/Q pairs, consumer of amplitudes
   modport master (
      output in_valid, in_i, in_q,
      input  in_ready, avalonst_source_data, avalonst_source_valid
   );

   // the magnitude stage itself
   modport slave (
      input  in_valid, in_i, in_q,
      output in_ready, avalonst_source_data, avalonst_source_valid
   );
endinterface

// File: rtl/lockin_amplitud_magnitud.sv
// Lock-in amplitude: floor(sqrt(I^2 + Q^2)) with a bit-serial restoring
// square root, emitted as a one-cycle Avalon-ST beat. Pairs offered while a
// computation runs are rejected and counted in a saturating counter.
module lockin_amplitud_magnitud #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   lockin_amplitud_magnitud_if.slave bus,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 busy,
   output logic [2:0]           state_dbg
);
   // R result bits; the radicand is padded to 2R bits
   localparam int R  = IN_W + 1;
   localparam int SW = 2 * R;
   localparam int CW = $clog2(R);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SQUARE = 3'd1,
      S_SUM    = 3'd2,
      S_ROOT   = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   state_t state, state_nx;

   logic signed [IN_W-1:0]   reg_i, reg_q;
   logic signed [2*IN_W-1:0] ext_i, ext_q, prod_i, prod_q;
   logic [2*IN_W-1:0]        sq_i, sq_q;
   logic [SW-1:0]            rad;
   logic [R:0]               rem, rem_nx;
   logic [R-1:0]             root, root_nx;
   logic [CW-1:0]            cnt;
   logic [OUT_W-1:0]         data;
   logic [R+2:0]             acc, trial, diff;
   logic                     fits, ready, valid, accept;
   logic [3:0]               unused_hi;

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // next-state logic; OUT can accept directly so back-to-back pairs see no gap
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_SQUARE;
         S_SQUARE: state_nx = S_SUM;
         S_SUM:    state_nx = S_ROOT;
         S_ROOT:   if (cnt == '0) state_nx = S_OUT;
         S_OUT:    state_nx = accept ? S_SQUARE : S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: ready in IDLE and during the result beat
   always_comb begin
      ready = 1'b0;
      valid = 1'b0;
      case (state)
         S_IDLE:  ready = 1'b1;
         S_OUT:   begin ready = 1'b1; valid = 1'b1; end
         default: ready = 1'b0;
      endcase
   end

   assign accept                    = bus.in_valid && ready;
   assign bus.in_ready              = ready;
   assign bus.avalonst_source_valid = valid;
   assign bus.avalonst_source_data  = data;
   assign busy                      = ~ready;
   assign state_dbg                 = state;

   // squares and one restoring-root step (trial divisor is 4*root + 1)
   always_comb begin
      ext_i   = $signed({{IN_W{reg_i[IN_W-1]}}, reg_i});
      ext_q   = $signed({{IN_W{reg_q[IN_W-1]}}, reg_q});
      prod_i  = ext_i * ext_i;
      prod_q  = ext_q * ext_q;
      acc     = {rem, rad[SW-1 -: 2]};
      trial   = {1'b0, root, 2'b01};
      fits    = (acc >= trial);
      diff    = acc - trial;
      rem_nx  = fits ? diff[R:0] : acc[R:0];
      root_nx = {root[R-2:0], fits};
      unused_hi = {acc[R+2:R+1], diff[R+2:R+1]};
   end

   // datapath registers, sequenced by the FSM state
   always_ff @(posedge clock) begin
      if (reset) begin
         reg_i <= '0;
         reg_q <= '0;
         sq_i  <= '0;
         sq_q  <= '0;
         rad   <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
         data  <= '0;
      end else begin
         case (state)
            S_IDLE, S_OUT: begin
               if (accept) begin
                  reg_i <= bus.in_i;
                  reg_q <= bus.in_q;
               end
            end
            S_SQUARE: begin
               sq_i <= $unsigned(prod_i);
               sq_q <= $unsigned(prod_q);
            end
            S_SUM: begin
               rad  <= {2'b00, sq_i} + {2'b00, sq_q};
               rem  <= '0;
               root <= '0;
               cnt  <= CW'(R - 1);
            end
            S_ROOT: begin
               rad  <= {rad[SW-3:0], 2'b00};
               rem  <= rem_nx;
               root <= root_nx;
               cnt  <= cnt - CW'(1);
               if (cnt == '0) data <= OUT_W'(root_nx);
            end
            default: ;
         endcase
      end
   end

   // saturating count of pairs offered while not ready
   always_ff @(posedge clock) begin
      if (reset)
         drop_count <= '0;
      else if (bus.in_valid && !ready && drop_count != '1)
         drop_count <= drop_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_lockin_amplitud_magnitud.sv
// Directed and random checks of the lock-in magnitude stage.
module tb_lockin_amplitud_magnitud;
   localparam int IN_W  = 24;
   localparam int OUT_W = 32;
   localparam int CNT_W = 16;
   localparam int LAT   = IN_W + 4;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   lockin_amplitud_magnitud_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
   lockin_amplitud_magnitud_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus2 ();

   logic [CNT_W-1:0] drop_count;
   logic             busy;
   logic [2:0]       state_dbg;
   logic [3:0]       drop_count2;
   logic             busy2;
   logic [2:0]       state_dbg2;

   lockin_amplitud_magnitud #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave),
      .drop_count(drop_count), .busy(busy), .state_dbg(state_dbg)
   );

   lockin_amplitud_magnitud #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(4)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave),
      .drop_count(drop_count2), .busy(busy2), .state_dbg(state_dbg2)
   );

   // scoreboard
   int n_total = 0;
   int n_bad   = 0;
   logic [OUT_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned isqrt(input longint unsigned s);
      longint unsigned r;
      r = longint'($floor($sqrt(real'(s))));
      while (r * r > s) r--;
      while ((r + 1) * (r + 1) <= s) r++;
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] mag(input int i, input int q);
      longint ii, qq;
      ii = i;
      qq = q;
      return OUT_W'(isqrt(longint'(ii * ii + qq * qq)));
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic one_pair(input string tag, input int i, input int q, input logic [OUT_W-1:0] exp);
      int lat = -1;
      int pulses = 0;
      int lowcnt = 0;
      logic [OUT_W-1:0] got = '0;
      bus.in_valid = 1'b1;
      bus.in_i = IN_W'(i);
      bus.in_q = IN_W'(q);
      chk({tag, "_ready"}, bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= LAT + 6; k++) begin
         if (bus.avalonst_source_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               got = bus.avalonst_source_data;
            end
         end
         if (k < LAT && !bus.in_ready && busy) lowcnt++;
         step();
      end
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_data"}, got, exp);
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_busy_cycles"}, lowcnt, LAT - 1);
      chk({tag, "_hold"}, bus.avalonst_source_data, exp);
   endtask

   // global time limit
   initial begin
      #5000000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int ti[6];
      int tq[6];
      logic [OUT_W-1:0] te[6];
      int accepts, valids, ready_err, vcycles, left, lowcnt;
      logic [IN_W-1:0] raw;
      int ri, rq;

      ti = '{-3, 0, 1, -8388608, 8388607, -8388608};
      tq = '{-4, 0, 1, -8388608, 0, 0};
      te = '{32'd5, 32'd0, 32'd1, 32'd11863283, 32'd8388607, 32'd8388608};

      bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0;
      bus2.in_valid = 1'b0; bus2.in_i = '0; bus2.in_q = '0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      // reset values
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", bus.avalonst_source_valid, 0);
      chk("rst_data", bus.avalonst_source_data, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_state", state_dbg, 0);

      // first pair straight after reset release
      one_pair("p3_4", 3, 4, 32'd5);
      chk("p3_4_drop", drop_count, 0);

      // signed and corner magnitudes
      for (int n = 0; n < 6; n++)
         one_pair($sformatf("corner%0d", n), ti[n], tq[n], te[n]);

      // in_valid held for 60 cycles with distinct pairs
      accepts = 0; valids = 0; ready_err = 0;
      for (int k = 0; k < 60 + LAT + 10; k++) begin
         if (bus.avalonst_source_valid) begin
            valids++;
            if (exp_q.size() == 0) chk("held_unexpected_valid", 1, 0);
            else chk("held_data", bus.avalonst_source_data, exp_q.pop_front());
         end
         if (k < 60) begin
            ri = k * 1000 + 7;
            rq = -(k * 333) - 1;
            bus.in_valid = 1'b1;
            bus.in_i = IN_W'(ri);
            bus.in_q = IN_W'(rq);
            if (bus.in_ready !== (k % LAT == 0)) ready_err++;
            if (bus.in_ready) accepts++;
            if (k % LAT == 0) exp_q.push_back(mag(ri, rq));
         end else begin
            bus.in_valid = 1'b0;
         end
         step();
      end
      chk("held_accepts", accepts, 3);
      chk("held_valids", valids, 3);
      chk("held_ready_pattern", ready_err, 0);
      chk("held_queue_empty", exp_q.size(), 0);
      chk("held_drop", drop_count, 57);

      // drop saturation on the 4-bit counter instance
      bus2.in_valid = 1'b1;
      bus2.in_i = IN_W'(3);
      bus2.in_q = IN_W'(4);
      repeat (15) step();
      chk("sat_drop14", drop_count2, 14);
      repeat (6) step();
      chk("sat_drop15", drop_count2, 15);
      bus2.in_valid = 1'b0;
      repeat (LAT + 4) step();

      // reset in the middle of a computation
      bus.in_valid = 1'b1;
      bus.in_i = IN_W'(3);
      bus.in_q = IN_W'(4);
      step();
      bus.in_valid = 1'b0;
      lowcnt = 0;
      for (int k = 1; k < 10; k++) begin
         if (bus.avalonst_source_valid) lowcnt++;
         step();
      end
      chk("midrst_no_valid", lowcnt, 0);
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_i = IN_W'(1);
      bus.in_q = IN_W'(1);
      step();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      chk("midrst_ready", bus.in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", bus.avalonst_source_valid, 0);
      chk("midrst_data", bus.avalonst_source_data, 0);
      chk("midrst_drop", drop_count, 0);
      chk("midrst_state", state_dbg, 0);
      one_pair("after_rst", 6, 8, 32'd10);

      // random traffic against the reference model
      reset = 1'b1;
      step();
      reset = 1'b0;
      accepts = 0; valids = 0; ready_err = 0; vcycles = 0; left = 0;
      for (int k = 0; k < 40000 + LAT + 10; k++) begin
         if (bus.avalonst_source_valid) begin
            valids++;
            if (exp_q.size() == 0) chk("rnd_unexpected_valid", 1, 0);
            else chk("rnd_data", bus.avalonst_source_data, exp_q.pop_front());
         end
         if (bus.in_ready !== (left == 0)) ready_err++;
         if (k < 40000 && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 7))
               0:       ri = -8388608;
               1:       ri = 8388607;
               default: begin raw = IN_W'($urandom); ri = $signed(raw); end
            endcase
            case ($urandom_range(0, 7))
               0:       rq = -8388608;
               1:       rq = 0;
               default: begin raw = IN_W'($urandom); rq = $signed(raw); end
            endcase
            bus.in_valid = 1'b1;
            bus.in_i = IN_W'(ri);
            bus.in_q = IN_W'(rq);
            vcycles++;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.in_valid && left == 0) begin
            accepts++;
            exp_q.push_back(mag(ri, rq));
            left = LAT - 1;
         end else if (left > 0) begin
            left--;
         end
         step();
      end
      chk("rnd_ready_model", ready_err, 0);
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_valid_eq_accept", valids, accepts);
      chk("rnd_accept_plus_drop", accepts + int'(drop_count), vcycles);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
